eprom_prog_seq: RTL
===================

# eprom_prog_seq

Programming sequencer for the PGM8755 8755A EPROM programmer. It sits directly downstream of the 2048×8 instruction buffer and walks the buffer from address 0 up to `LAST_ADDR`. For each byte it drives the EPROM's multiplexed AD bus, high address lines, ALE, and the timed PROG pulse under the programming-voltage enable. It reports progress, completion, and (optionally) read-back verify failure.

## Interface
Parameters:
- `LAST_ADDR`, 2047: final buffer/EPROM address programmed (inclusive).
- `VDD_SETTLE_CYC`, 500000: cycles between `vdd_en` rise/fall and first/last bus activity (10 ms at 50 MHz).
- `SETUP_CYC`, 50: data/address setup before PROG rises and hold after PROG falls.
- `PULSE_CYC`, 2500000: PROG high width (50 ms at 50 MHz).

Ports:
- `clk`, in, 1: system clock.
- `rst`, in, 1: synchronous, active-high reset.
- `start`, in, 1: one-cycle request to begin a programming run.
- `buf_rd`, out, 1: buffer direction select; 1 = buffer in read mode. Equals `busy`.
- `buf_addr`, out, 11: buffer read address.
- `buf_data`, in, 8: buffer read data, valid one cycle after `buf_addr`.
- `ad_out`, out, 8: EPROM AD0–AD7 drive value.
- `ad_oe`, out, 1: AD bus output enable.
- `ad_in`, in, 8: AD bus sampled value (verify path).
- `a_hi`, out, 3: EPROM A8–A10.
- `ale`, out, 1: address latch enable.
- `rd_n`, out, 1: EPROM read strobe, active low.
- `prog`, out, 1: programming pulse, active high.
- `vdd_en`, out, 1: programming-supply enable.
- `busy`, out, 1: run in progress.
- `done`, out, 1: one-cycle pulse at run end, success or failure.
- `error`, out, 1: sticky verify failure; cleared by `start` or `rst`.
- `err_addr`, out, 11: address of first failing byte.

## Operation
- Reset values: `buf_addr=0`, `ad_out=0`, `ad_oe=0`, `a_hi=0`, `ale=0`, `rd_n=1`, `prog=0`, `vdd_en=0`, `busy=0`, `done=0`, `error=0`, `err_addr=0`; FSM enters IDLE.
- FSM states: IDLE → VDD_ON → FETCH → WAIT → ADDR → SETUP → PULSE → HOLD → [VRD → VCMP] → NEXT → VDD_OFF → FIN → IDLE.
- IDLE: on `start`, clear `error` and set address counter to 0. Raise `busy` and `vdd_en`, then go to VDD_ON.
- VDD_ON: wait `VDD_SETTLE_CYC` cycles.
- FETCH: present `buf_addr`.
- WAIT: one cycle for buffer read latency; capture `buf_data` into a data register at the end of WAIT.
- ADDR: drive `ad_out` = addr[7:0] and `a_hi` = addr[10:8], with `ad_oe=1` and `ale=1` for exactly 1 cycle.
- SETUP: drop `ale` and drive `ad_out` = data register for `SETUP_CYC` cycles.
- PULSE: `prog=1` for exactly `PULSE_CYC` cycles.
- HOLD: `prog=0`, data held for `SETUP_CYC` cycles.
- NEXT: if addr == `LAST_ADDR`, go to VDD_OFF. Otherwise increment addr and go to FETCH.
- VDD_OFF: `ad_oe=0` and `vdd_en=0`, then wait `VDD_SETTLE_CYC` cycles.
- FIN: `done=1` for 1 cycle, `busy=0`, return to IDLE.
- Timing uses a single down-counter sized `$clog2` of the largest cycle parameter plus 1. The address counter is 11 bits and never wraps; the run terminates at `LAST_ADDR`.
- `start` while `busy` is ignored. `buf_data` is ignored outside WAIT.
- `rst` mid-run: all outputs return to reset values at that edge. `vdd_en` and `prog` fall immediately, and no `done` is issued.

## Timing
- `start` edge → `vdd_en=1` and `busy=1` on the next cycle.
- Per-byte period without verify = `2*SETUP_CYC + PULSE_CYC + 4` cycles (FETCH, WAIT, ADDR, NEXT).
- Per-byte period with `VERIFY_EN` = `2*SETUP_CYC + PULSE_CYC + 4 + SETUP_CYC + 1`.
- Total run = `2*VDD_SETTLE_CYC + (LAST_ADDR+1)*per-byte + 2` cycles (VDD_ON/VDD_OFF settle windows, the per-byte loop, and the IDLE→VDD_ON entry plus FIN cycle).
- `prog` is never high while `ale=1`, while `ad_oe=0`, or while `vdd_en=0`.

## Configuration
- `PGM_VERIFY_EN` defined: after HOLD, enter VRD. VRD sets `ad_oe=0` and `rd_n=0` for `SETUP_CYC` cycles. VCMP then samples `ad_in` for 1 cycle and deasserts `rd_n`.
  - On mismatch: set `error`, latch `err_addr`, and skip straight to VDD_OFF, aborting the remaining bytes.
  - On match: continue to NEXT.
- `PGM_VERIFY_EN` undefined: VRD/VCMP are absent, `rd_n` is tied 1, and `error`/`err_addr` are tied 0.

## Test plan
Use `LAST_ADDR=3`, `VDD_SETTLE_CYC=4`, `SETUP_CYC=2`, `PULSE_CYC=5` unless noted.
- Buffer holds 0xA5, 0x3C, 0xFF, 0x00 at 0–3; pulse `start` → four PROG pulses of 5 cycles each; `ad_out` during PULSE = A5, 3C, FF, 00; `a_hi=0`; one `done`; `error=0`.
- Same run → `ale` asserts 1 cycle per byte with `ad_out` = 00, 01, 02, 03; no overlap of `prog` with `ale`; total cycle count matches the Timing formulas.
- `LAST_ADDR=2047`, short timers → `a_hi` reaches 7 and `buf_addr` reaches 0x7FF; run ends with exactly 2048 PROG pulses and no wrap to 0.
- `start` re-pulsed mid-run, then `rst` asserted during PULSE of byte 2 → restart ignored; `prog` and `vdd_en` go low at the reset edge; all outputs at reset values; no `done`.
- `PGM_VERIFY_EN`, `ad_in` model returns 0x3D at address 1 (expected 0x3C) → `error=1`, `err_addr=1`, no PROG for addresses 2–3, `done` pulses once after VDD_OFF.
- `PGM_VERIFY_EN`, `ad_in` correct → `rd_n` low for 2 cycles per byte, `error=0`.

Source files
------------

// File: rtl/eprom_prog_seq.sv
// eprom_prog_seq: programming sequencer for an 8755A-style EPROM.
// Walks the instruction buffer from address 0 to LAST_ADDR. For each byte it
// latches the address with ALE, sets up the data, issues a timed PROG pulse
// and holds the data afterwards, all with the programming supply enabled.
// Optional feature macro: PGM_VERIFY_EN adds a read-back compare after each byte.
// Each timed window must be at least one cycle long, so every cycle parameter
// must be 1 or greater.
module eprom_prog_seq #(
  parameter int LAST_ADDR      = 2047,
  parameter int VDD_SETTLE_CYC = 500000,
  parameter int SETUP_CYC      = 50,
  parameter int PULSE_CYC      = 2500000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic        buf_rd,
  output logic [10:0] buf_addr,
  input  logic [7:0]  buf_data,
  output logic [7:0]  ad_out,
  output logic        ad_oe,
  input  logic [7:0]  ad_in,
  output logic [2:0]  a_hi,
  output logic        ale,
  output logic        rd_n,
  output logic        prog,
  output logic        vdd_en,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [10:0] err_addr
);

  // One shared down-counter times every window, so it is sized for the longest.
  localparam int MAX_VP  = (VDD_SETTLE_CYC > PULSE_CYC) ? VDD_SETTLE_CYC : PULSE_CYC;
  localparam int MAX_CYC = (MAX_VP > SETUP_CYC) ? MAX_VP : SETUP_CYC;
  localparam int CNT_W   = $clog2(MAX_CYC) + 1;

  localparam logic [CNT_W-1:0] VDD_LOAD   = CNT_W'(VDD_SETTLE_CYC - 1);
  localparam logic [CNT_W-1:0] SETUP_LOAD = CNT_W'(SETUP_CYC - 1);
  localparam logic [CNT_W-1:0] PULSE_LOAD = CNT_W'(PULSE_CYC - 1);
  localparam logic [10:0]      LAST       = 11'(LAST_ADDR);

  localparam logic [3:0] ST_IDLE    = 4'd0;
  localparam logic [3:0] ST_VDD_ON  = 4'd1;
  localparam logic [3:0] ST_FETCH   = 4'd2;
  localparam logic [3:0] ST_WAIT    = 4'd3;
  localparam logic [3:0] ST_ADDR    = 4'd4;
  localparam logic [3:0] ST_SETUP   = 4'd5;
  localparam logic [3:0] ST_PULSE   = 4'd6;
  localparam logic [3:0] ST_HOLD    = 4'd7;
`ifdef PGM_VERIFY_EN
  localparam logic [3:0] ST_VRD     = 4'd8;
  localparam logic [3:0] ST_VCMP    = 4'd9;
`endif
  localparam logic [3:0] ST_NEXT    = 4'd10;
  localparam logic [3:0] ST_VDD_OFF = 4'd11;
  localparam logic [3:0] ST_FIN     = 4'd12;

  logic [3:0]       state_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic [10:0]      addr_reg;
  logic [7:0]       data_reg;
  logic             cnt_zero;

  assign cnt_zero = (cnt_reg == '0);

`ifdef PGM_VERIFY_EN
  logic        error_reg;
  logic [10:0] err_addr_reg;
`else
  // Read-back bus is not observed when verify is compiled out.
  logic [7:0] ad_in_unused;
  assign ad_in_unused = ad_in;
`endif

  // Sequencer FSM: state, window counter, byte address and data capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= ST_IDLE;
      cnt_reg   <= '0;
      addr_reg  <= '0;
      data_reg  <= '0;
`ifdef PGM_VERIFY_EN
      error_reg    <= 1'b0;
      err_addr_reg <= '0;
`endif
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (start) begin
            addr_reg  <= '0;
            cnt_reg   <= VDD_LOAD;
            state_reg <= ST_VDD_ON;
`ifdef PGM_VERIFY_EN
            error_reg <= 1'b0;
`endif
          end
        end
        ST_VDD_ON: begin
          if (cnt_zero) state_reg <= ST_FETCH;
          else          cnt_reg   <= cnt_reg - 1'b1;
        end
        ST_FETCH: state_reg <= ST_WAIT;
        ST_WAIT: begin
          data_reg  <= buf_data;
          state_reg <= ST_ADDR;
        end
        ST_ADDR: begin
          cnt_reg   <= SETUP_LOAD;
          state_reg <= ST_SETUP;
        end
        ST_SETUP: begin
          if (cnt_zero) begin
            cnt_reg   <= PULSE_LOAD;
            state_reg <= ST_PULSE;
          end else begin
            cnt_reg <= cnt_reg - 1'b1;
          end
        end
        ST_PULSE: begin
          if (cnt_zero) begin
            cnt_reg   <= SETUP_LOAD;
            state_reg <= ST_HOLD;
          end else begin
            cnt_reg <= cnt_reg - 1'b1;
          end
        end
        ST_HOLD: begin
          if (cnt_zero) begin
`ifdef PGM_VERIFY_EN
            cnt_reg   <= SETUP_LOAD;
            state_reg <= ST_VRD;
`else
            state_reg <= ST_NEXT;
`endif
          end else begin
            cnt_reg <= cnt_reg - 1'b1;
          end
        end
`ifdef PGM_VERIFY_EN
        ST_VRD: begin
          if (cnt_zero) state_reg <= ST_VCMP;
          else          cnt_reg   <= cnt_reg - 1'b1;
        end
        ST_VCMP: begin
          // A bad byte aborts the run; the supply still ramps down normally.
          if (ad_in != data_reg) begin
            error_reg    <= 1'b1;
            err_addr_reg <= addr_reg;
            cnt_reg      <= VDD_LOAD;
            state_reg    <= ST_VDD_OFF;
          end else begin
            state_reg <= ST_NEXT;
          end
        end
`endif
        ST_NEXT: begin
          // Stop at the last address so the counter never wraps.
          if (addr_reg == LAST) begin
            cnt_reg   <= VDD_LOAD;
            state_reg <= ST_VDD_OFF;
          end else begin
            addr_reg  <= addr_reg + 1'b1;
            state_reg <= ST_FETCH;
          end
        end
        ST_VDD_OFF: begin
          if (cnt_zero) state_reg <= ST_FIN;
          else          cnt_reg   <= cnt_reg - 1'b1;
        end
        ST_FIN:  state_reg <= ST_IDLE;
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  // EPROM bus decode: address phase, data phase and the PROG window.
  always_comb begin
    ad_out = 8'h00;
    ad_oe  = 1'b0;
    ale    = 1'b0;
    prog   = 1'b0;
    case (state_reg)
      ST_ADDR: begin
        ad_out = addr_reg[7:0];
        ad_oe  = 1'b1;
        ale    = 1'b1;
      end
      ST_SETUP, ST_HOLD: begin
        ad_out = data_reg;
        ad_oe  = 1'b1;
      end
      ST_PULSE: begin
        ad_out = data_reg;
        ad_oe  = 1'b1;
        prog   = 1'b1;
      end
      default: ;
    endcase
  end

  // Supply is up from VDD_ON through the last byte; it drops for the VDD_OFF settle.
  assign busy     = (state_reg != ST_IDLE) && (state_reg != ST_FIN);
  assign vdd_en   = busy && (state_reg != ST_VDD_OFF);
  assign buf_rd   = busy;
  assign buf_addr = addr_reg;
  assign a_hi     = busy ? addr_reg[10:8] : 3'd0;
  assign done     = (state_reg == ST_FIN);

`ifdef PGM_VERIFY_EN
  assign rd_n     = (state_reg != ST_VRD);
  assign error    = error_reg;
  assign err_addr = err_addr_reg;
`else
  assign rd_n     = 1'b1;
  assign error    = 1'b0;
  assign err_addr = 11'd0;
`endif

endmodule
